// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings {funct7[5],funct3}
// and the legality check used by the arbiter's opcode filter.
package alu_pkg;

  typedef logic [3:0] alu_opcode_t;

  localparam alu_opcode_t ALU_ADD  = 4'b0000;
  localparam alu_opcode_t ALU_SUB  = 4'b1000;
  localparam alu_opcode_t ALU_SLT  = 4'b0010;
  localparam alu_opcode_t ALU_SLTU = 4'b0011;
  localparam alu_opcode_t ALU_AND  = 4'b0111;
  localparam alu_opcode_t ALU_OR   = 4'b0110;
  localparam alu_opcode_t ALU_XOR  = 4'b0100;
  localparam alu_opcode_t ALU_SLL  = 4'b0001;
  localparam alu_opcode_t ALU_SRL  = 4'b0101;
  localparam alu_opcode_t ALU_SRA  = 4'b1101;

  function automatic logic is_legal_alu_op(
    input alu_opcode_t op
  );
    case (op)
      ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU,
      ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Round-robin arbiter: wrap-around priority search
// starting at rr_ptr; pointer advances past the winner on update.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any,
  output logic [ID_W-1:0]    ptr
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (update) begin
      ptr <= (idx == ID_W'(NUM_REQ - 1))
           ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters with a registered response.
// Optional opcode check enabled by ALU_ARB_OPCHK_EN (adds rsp_err_out).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [NUM_REQ-1:0]      req_valid_in,
  output logic [NUM_REQ-1:0]      req_ready_out,
  input  logic [NUM_REQ*32-1:0]   req_op_1_in,
  input  logic [NUM_REQ*32-1:0]   req_op_2_in,
  input  logic [NUM_REQ*4-1:0]    req_opcode_in,
  output logic [31:0]             alu_op_1_out,
  output logic [31:0]             alu_op_2_out,
  output logic [3:0]              alu_opcode_out,
  input  logic [31:0]             alu_result_in,
  output logic                    rsp_valid_out,
  input  logic                    rsp_ready_in,
  output logic [31:0]             rsp_result_out,
  output logic [ID_W-1:0]         rsp_id_out
`ifdef ALU_ARB_OPCHK_EN
  ,
  output logic                    rsp_err_out
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    idx;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    sel;
  logic               any;
  logic               can_accept;
  logic               accept;
  logic               legal;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .req    (req_valid_in),
    .update (accept),
    .grant  (grant),
    .idx    (idx),
    .any    (any),
    .ptr    (ptr)
  );

  assign can_accept = (state == EMPTY)
                    | (rsp_valid_out & rsp_ready_in);

  assign req_ready_out = rst_n_in
                       ? (grant & {NUM_REQ{can_accept}})
                       : '0;

  assign accept = |(req_valid_in & req_ready_out);

  // Idle cycles still present rr_ptr's fields; the ALU output is ignored.
  assign sel = any ? idx : ptr;

  assign alu_op_1_out   = req_op_1_in[int'(sel)*32 +: 32];
  assign alu_op_2_out   = req_op_2_in[int'(sel)*32 +: 32];
  assign alu_opcode_out = req_opcode_in[int'(sel)*4 +: 4];

`ifdef ALU_ARB_OPCHK_EN
  assign legal = is_legal_alu_op(alu_opcode_out);
`else
  assign legal = 1'b1;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state          <= EMPTY;
      rsp_valid_out  <= 1'b0;
      rsp_result_out <= '0;
      rsp_id_out     <= '0;
`ifdef ALU_ARB_OPCHK_EN
      rsp_err_out    <= 1'b0;
`endif
    end else if (accept) begin
      state          <= FULL;
      rsp_valid_out  <= 1'b1;
      rsp_result_out <= legal ? alu_result_in : '0;
      rsp_id_out     <= idx;
`ifdef ALU_ARB_OPCHK_EN
      rsp_err_out    <= ~legal;
`endif
    end else if (rsp_valid_out & rsp_ready_in) begin
      state          <= EMPTY;
      rsp_valid_out  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a 2-requester and a 3-requester instance
// sharing clock and reset, each driven by a reference ALU model.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  function automatic logic [31:0] alu_f(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  op
  );
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0010: return {31'd0, $signed(a) < $signed(b)};
      4'b0011: return {31'd0, a < b};
      4'b0111: return a & b;
      4'b0110: return a | b;
      4'b0100: return a ^ b;
      4'b0001: return a << b[4:0];
      4'b0101: return a >> b[4:0];
      4'b1101: return $signed(a) >>> b[4:0];
      default: return 32'hFFFF_0000 ^ a ^ b;
    endcase
  endfunction

  // instance A: NUM_REQ=2
  logic [1:0]  a_valid;
  logic [1:0]  a_ready;
  logic [63:0] a_op1;
  logic [63:0] a_op2;
  logic [7:0]  a_opc;
  logic [31:0] a_alu1;
  logic [31:0] a_alu2;
  logic [3:0]  a_aluc;
  logic [31:0] a_alures;
  logic        a_rv;
  logic        a_rr;
  logic [31:0] a_res;
  logic [0:0]  a_id;
`ifdef ALU_ARB_OPCHK_EN
  logic        a_err;
`endif

  assign a_alures = alu_f(a_alu1, a_alu2, a_aluc);

  alu_arbiter #(.NUM_REQ(2), .ID_W(1)) dut_a (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .req_valid_in   (a_valid),
    .req_ready_out  (a_ready),
    .req_op_1_in    (a_op1),
    .req_op_2_in    (a_op2),
    .req_opcode_in  (a_opc),
    .alu_op_1_out   (a_alu1),
    .alu_op_2_out   (a_alu2),
    .alu_opcode_out (a_aluc),
    .alu_result_in  (a_alures),
    .rsp_valid_out  (a_rv),
    .rsp_ready_in   (a_rr),
    .rsp_result_out (a_res),
    .rsp_id_out     (a_id)
`ifdef ALU_ARB_OPCHK_EN
    ,
    .rsp_err_out    (a_err)
`endif
  );

  // instance B: NUM_REQ=3
  logic [2:0]  b_valid;
  logic [2:0]  b_ready;
  logic [95:0] b_op1;
  logic [95:0] b_op2;
  logic [11:0] b_opc;
  logic [31:0] b_alu1;
  logic [31:0] b_alu2;
  logic [3:0]  b_aluc;
  logic [31:0] b_alures;
  logic        b_rv;
  logic        b_rr;
  logic [31:0] b_res;
  logic [1:0]  b_id;
`ifdef ALU_ARB_OPCHK_EN
  logic        b_err;
`endif

  assign b_alures = alu_f(b_alu1, b_alu2, b_aluc);

  alu_arbiter #(.NUM_REQ(3), .ID_W(2)) dut_b (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .req_valid_in   (b_valid),
    .req_ready_out  (b_ready),
    .req_op_1_in    (b_op1),
    .req_op_2_in    (b_op2),
    .req_opcode_in  (b_opc),
    .alu_op_1_out   (b_alu1),
    .alu_op_2_out   (b_alu2),
    .alu_opcode_out (b_aluc),
    .alu_result_in  (b_alures),
    .rsp_valid_out  (b_rv),
    .rsp_ready_in   (b_rr),
    .rsp_result_out (b_res),
    .rsp_id_out     (b_id)
`ifdef ALU_ARB_OPCHK_EN
    ,
    .rsp_err_out    (b_err)
`endif
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    a_valid = 2'b11;
    a_rr    = 1'b0;
    a_op1   = '0;
    a_op2   = '0;
    a_opc   = '0;
    b_valid = 3'b000;
    b_rr    = 1'b0;
    b_op1   = '0;
    b_op2   = '0;
    b_opc   = '0;

    // reset state
    #1;
    chk("rst_ready_low", 32'(a_ready), 32'h0);
    tick;
    tick;
    chk("rst_rv", 32'(a_rv), 32'h0);
    chk("rst_res", a_res, 32'h0);
    chk("rst_id", 32'(a_id), 32'h0);
    chk("rst_b_rv", 32'(b_rv), 32'h0);
    rst_n   = 1'b1;
    a_valid = 2'b00;

    // single requester: SUB 7-5
    a_valid       = 2'b01;
    a_op1[31:0]   = 32'd7;
    a_op2[31:0]   = 32'd5;
    a_opc[3:0]    = 4'b1000;
    #1;
    chk("single_ready", 32'(a_ready), 32'h1);
    chk("single_alu_op1", a_alu1, 32'd7);
    chk("single_alu_opc", 32'(a_aluc), 32'h8);
    tick;
    a_valid = 2'b00;
    chk("single_rv", 32'(a_rv), 32'h1);
    chk("single_res", a_res, 32'd2);
    chk("single_id", 32'(a_id), 32'h0);
    a_rr = 1'b1;
    tick;
    chk("single_drain", 32'(a_rv), 32'h0);

    // contention: r0 ADD 10+3, r1 SUB 10-3; pointer at 1
    a_op1       = {32'd10, 32'd10};
    a_op2       = {32'd3, 32'd3};
    a_opc       = {4'b1000, 4'b0000};
    a_valid     = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_ready", 32'(a_ready),
          (k % 2 == 0) ? 32'h2 : 32'h1);
      tick;
      chk("cont_rv", 32'(a_rv), 32'h1);
      chk("cont_id", 32'(a_id),
          (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("cont_res", a_res,
          (k % 2 == 0) ? 32'd7 : 32'd13);
    end

    // backpressure: hold r0's result for 3 cycles
    a_rr = 1'b0;
    #1;
    chk("bp_ready0", 32'(a_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("bp_rv", 32'(a_rv), 32'h1);
      chk("bp_res", a_res, 32'd13);
      chk("bp_id", 32'(a_id), 32'h0);
      chk("bp_ready", 32'(a_ready), 32'h0);
    end
    a_rr = 1'b1;
    #1;
    chk("bp_release_ready", 32'(a_ready), 32'h2);
    tick;
    chk("bp_release_res", a_res, 32'd7);
    chk("bp_release_id", 32'(a_id), 32'h1);
    a_valid = 2'b00;
    tick;
    chk("bp_drain", 32'(a_rv), 32'h0);

    // opcode 1111 on r0: F0 / 0F
    a_valid     = 2'b01;
    a_op1[31:0] = 32'h0000_00F0;
    a_op2[31:0] = 32'h0000_000F;
    a_opc[3:0]  = 4'b1111;
    #1;
    chk("illop_passthru", 32'(a_aluc), 32'hF);
    tick;
    chk("illop_rv", 32'(a_rv), 32'h1);
`ifdef ALU_ARB_OPCHK_EN
    chk("illop_res", a_res, 32'h0);
    chk("illop_err", 32'(a_err), 32'h1);
`else
    chk("illop_res", a_res, 32'hFFFF_00FF);
`endif

    // load 2+3 on r1, then reset mid-response
    a_valid      = 2'b10;
    a_op1[63:32] = 32'd2;
    a_op2[63:32] = 32'd3;
    a_opc[7:4]   = 4'b0000;
    #1;
    chk("pre_rst_ready", 32'(a_ready), 32'h2);
    tick;
    chk("pre_rst_res", a_res, 32'd5);
    chk("pre_rst_id", 32'(a_id), 32'h1);
`ifdef ALU_ARB_OPCHK_EN
    chk("legal_err", 32'(a_err), 32'h0);
`endif
    a_valid = 2'b11;
    a_rr    = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("midrst_ready", 32'(a_ready), 32'h0);
    tick;
    chk("midrst_rv", 32'(a_rv), 32'h0);
    chk("midrst_res", a_res, 32'h0);
    chk("midrst_id", 32'(a_id), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("postrst_ready", 32'(a_ready), 32'h1);
    a_valid = 2'b00;

    // pointer wrap on 3 requesters
    b_rr          = 1'b1;
    b_valid       = 3'b100;
    b_op1[95:64]  = 32'd9;
    b_op2[95:64]  = 32'd4;
    b_opc[11:8]   = 4'b0100;
    #1;
    chk("wrap_ready_r2", 32'(b_ready), 32'h4);
    tick;
    chk("wrap_id_r2", 32'(b_id), 32'h2);
    chk("wrap_res_r2", b_res, 32'd13);
    b_valid       = 3'b101;
    b_op1[31:0]   = 32'hC;
    b_op2[31:0]   = 32'hA;
    b_opc[3:0]    = 4'b0111;
    #1;
    chk("wrap_ready_r0", 32'(b_ready), 32'h1);
    tick;
    chk("wrap_id_r0", 32'(b_id), 32'h0);
    chk("wrap_res_r0", b_res, 32'h8);
    b_valid       = 3'b110;
    b_op1[63:32]  = 32'd1;
    b_op2[63:32]  = 32'd2;
    b_opc[7:4]    = 4'b0110;
    #1;
    chk("wrap_ready_r1", 32'(b_ready), 32'h2);
    tick;
    chk("wrap_id_r1", 32'(b_id), 32'h1);
    chk("wrap_res_r1", b_res, 32'd3);
    b_valid = 3'b000;
    tick;
    chk("wrap_drain", 32'(b_rv), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between NUM_REQ requesters, e.g. the integer pipe and the address/branch-compare unit.
- Round-robin grant picks at most one request per cycle and drives it onto the ALU operand/opcode ports.
- The ALU result is captured into a one-entry response register, tagged with the requester id, and released through a valid/ready handshake.
- Sits between the decode/issue logic and the ALU.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, requester id width; must equal max(1, clog2(NUM_REQ)).

Ports:
- clk_in  input  1  clock; all state updates on its rising edge.
- rst_n_in  input  1  reset; synchronous, active-low.
- req_valid_in  input  NUM_REQ  per-requester request valid.
- req_ready_out  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_op_1_in  input  NUM_REQ*32  operand 1; requester i occupies bits [32i+31:32i].
- req_op_2_in  input  NUM_REQ*32  operand 2; same packing.
- req_opcode_in  input  NUM_REQ*4  ALU opcode {funct7[5],funct3}; requester i occupies [4i+3:4i].
- alu_op_1_out  output  32  operand 1 to ALU.
- alu_op_2_out  output  32  operand 2 to ALU.
- alu_opcode_out  output  4  opcode to ALU.
- alu_result_in  input  32  combinational ALU result.
- rsp_valid_out  output  1  response valid.
- rsp_ready_in  input  1  response consumer ready.
- rsp_result_out  output  32  registered result.
- rsp_id_out  output  ID_W  index of the requester that produced the result.

Behaviour:
- Reset (rst_n_in low at a clock edge):
  - rsp_valid_out=0, rsp_result_out=0, rsp_id_out=0, rr_ptr=0.
  - FSM returns to EMPTY.
  - req_ready_out is forced 0 while rst_n_in is low.
  - An in-flight response is discarded.
- FSM states:
  - EMPTY: response register free.
  - FULL: rsp_valid_out=1.
- can_accept = (state==EMPTY) | (rsp_valid_out & rsp_ready_in).
- Grant:
  - Search req_valid_in starting at rr_ptr, wrapping NUM_REQ-1 -> 0; the first set bit wins.
  - No valid request means no grant.
  - Grant is combinational from req_valid_in and rr_ptr.
- req_ready_out[g] = can_accept for the granted g; all other bits are 0. Accept = valid & ready in the same cycle.
- ALU drive:
  - alu_*_out carry the granted requester's fields.
  - With no grant they carry requester rr_ptr's fields; the consumer ignores them.
- On accept of requester g:
  - Next edge: rsp_result_out <= alu_result_in, rsp_id_out <= g, state <= FULL.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Latency: accept in cycle T gives rsp_valid_out=1 in T+1. Throughput is one operation per cycle when rsp_ready_in is held high.
- In FULL:
  - rsp_ready_in=0: hold the result and id stable, all req_ready_out=0.
  - rsp_ready_in=1 with a new accept: reload and stay FULL.
  - rsp_ready_in=1 with no accept: go to EMPTY, rsp_valid_out=0.
- rr_ptr changes only on accept. A requester that is never accepted keeps its position.
- Requesters may drop valid without being accepted; there is no stickiness.
- The opcode is passed unmodified to the ALU.

Optional Feature:
- Macro: ALU_ARB_OPCHK_EN.
- When defined:
  - Adds output rsp_err_out (1 bit, reset 0), registered alongside rsp_result_out.
  - rsp_err_out is set when the accepted opcode is not one of ADD 0000, SUB 1000, SLT 0010, SLTU 0011, AND 0111, OR 0110, XOR 0100, SLL 0001, SRL 0101, SRA 1101.
  - For an illegal opcode, rsp_result_out is forced to 0 while the handshake and timing stay unchanged.
- When undefined: no rsp_err_out port, and every opcode is treated as legal.

Decomposition:
- Shared package alu_pkg:
  - The ten 4-bit ALU opcode constants above.
  - The alu_opcode_t typedef.
  - Function is_legal_alu_op used by the opcode check.
- One natural sub-module: rr_arbiter, holding rr_ptr and the wrap-around priority search. It takes NUM_REQ, the request vector and an update enable, and returns a one-hot grant plus the encoded index.

Test Plan:
1. Reset mid-response: FULL with result 0x5, assert rst_n_in low for one edge -> rsp_valid_out=0 and rsp_result_out=0 next cycle; req_ready_out=0 while low.
2. Single requester: r0 sends op1=7, op2=5, opcode 1000, ALU model returns 2 -> rsp_valid_out at T+1, result 2, id 0.
3. Contention: both valid every cycle with rsp_ready_in=1 -> grants alternate 0,1,0,1; responses arrive one per cycle with ids alternating.
4. Backpressure: rsp_ready_in=0 for 3 cycles while FULL -> result and id stable, req_ready_out=00 throughout; on release, accept resumes the same cycle.
5. Pointer wrap (NUM_REQ=3): requests only from r2, then r0 and r2 together -> r2 first, then r0 (rr_ptr wrapped to 0).
6. With ALU_ARB_OPCHK_EN defined, opcode 1111 -> rsp_err_out=1, rsp_result_out=0. With the macro undefined, the same opcode gives the ALU result unchanged.
